sort_ram_responder: RTL and testbench

SORT_RAM_RESPONDER -- requirements
Module: sort_ram_responder

---
 rtl/sort_ram_responder.sv | 141 ++++++++++++++
 tb/tb_sort_ram_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_ram_responder.sv
// Single-port RAM responder for the sort datapath: fixed-latency reads,
// same-cycle writes, read/write conflict flagging, optional parity.
//
// Optional feature macro: SORT_RAM_PARITY_EN (per-word even parity).
//
// Parameters:
//   SIZE_ADDR  - address width, depth is 2**SIZE_ADDR words
//   SIZE_DATA  - data word width
//   RD_LATENCY - read latency in clock edges (1..15)
// Ports:
//   i_clk          - clock, rising edge
//   i_rst          - asynchronous active-high reset
//   i_rd_en        - read request strobe
//   i_wr_en        - write request strobe
//   i_addr_ram     - request address
//   i_data_ram     - write data
//   i_flip_par     - store inverted parity on write (error injection)
//   o_data_ram     - read data, held until the next read completes
//   o_valid_rd     - one-cycle pulse qualifying o_data_ram
//   o_valid_wr     - one-cycle write acknowledge
//   o_busy         - high while a read is outstanding
//   o_err_conflict - one-cycle pulse on a rejected read+write request
//   o_parity_err   - parity mismatch, valid with o_valid_rd
module sort_ram_responder #(
    parameter int SIZE_ADDR  = 8,
    parameter int SIZE_DATA  = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rd_en,
    input  logic                 i_wr_en,
    input  logic [SIZE_ADDR-1:0] i_addr_ram,
    input  logic [SIZE_DATA-1:0] i_data_ram,
    input  logic                 i_flip_par,
    output logic [SIZE_DATA-1:0] o_data_ram,
    output logic                 o_valid_rd,
    output logic                 o_valid_wr,
    output logic                 o_busy,
    output logic                 o_err_conflict,
    output logic                 o_parity_err
);

    localparam int DEPTH = 2 ** SIZE_ADDR;
    localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [SIZE_ADDR-1:0] addr_q;

    logic [SIZE_DATA-1:0] mem [DEPTH];

    logic                 conflict;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 bypass;
    logic [SIZE_DATA-1:0] rd_word;
    logic                 rd_par_bad;

    assign conflict = i_rd_en & i_wr_en;
    assign wr_acc   = i_wr_en & ~i_rd_en;
    assign rd_acc   = i_rd_en & ~i_wr_en & (state == IDLE);
    assign o_busy   = (state == RD_WAIT);

    // A write landing on the completing edge to the outstanding address
    // must still be seen by that read, so forward it past the array.
    assign bypass  = wr_acc && (i_addr_ram == addr_q);
    assign rd_word = bypass ? i_data_ram : mem[addr_q];

    // Array is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) begin
            mem[i_addr_ram] <= i_data_ram;
        end
    end

`ifdef SORT_RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_wr;
    logic par_rd;

    assign par_wr = (^i_data_ram) ^ i_flip_par;
    assign par_rd = bypass ? par_wr : par_mem[addr_q];
    assign rd_par_bad = par_rd ^ (^rd_word);

    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) begin
            par_mem[i_addr_ram] <= par_wr;
        end
    end
`else
    logic unused_flip_par;

    assign unused_flip_par = i_flip_par;
    assign rd_par_bad = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            o_data_ram     <= '0;
            o_valid_rd     <= 1'b0;
            o_valid_wr     <= 1'b0;
            o_err_conflict <= 1'b0;
            o_parity_err   <= 1'b0;
        end else begin
            o_valid_rd     <= 1'b0;
            o_parity_err   <= 1'b0;
            o_valid_wr     <= wr_acc;
            o_err_conflict <= conflict;
            unique case (state)
                IDLE: begin
                    if (rd_acc) begin
                        addr_q <= i_addr_ram;
                        cnt    <= LAT_LOAD;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= IDLE;
                        o_data_ram   <= rd_word;
                        o_valid_rd   <= 1'b1;
                        o_parity_err <= rd_par_bad;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_ram_responder.sv
// Directed self-checking bench for sort_ram_responder
// (SIZE_ADDR=8, SIZE_DATA=8, RD_LATENCY=2).
module tb_sort_ram_responder;

    logic       clk;
    logic       rst;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       flip;
    logic [7:0] rdata;
    logic       valid_rd;
    logic       valid_wr;
    logic       busy;
    logic       err_conf;
    logic       par_err;

    int errors = 0;
    int checks = 0;
    int vr_cnt = 0;

    sort_ram_responder #(
        .SIZE_ADDR(8),
        .SIZE_DATA(8),
        .RD_LATENCY(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rd_en(rd_en),
        .i_wr_en(wr_en),
        .i_addr_ram(addr),
        .i_data_ram(wdata),
        .i_flip_par(flip),
        .o_data_ram(rdata),
        .o_valid_rd(valid_rd),
        .o_valid_wr(valid_wr),
        .o_busy(busy),
        .o_err_conflict(err_conf),
        .o_parity_err(par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (valid_rd === 1'b1) vr_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus helpers only; comparisons live in the scenario tasks.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            input logic f);
        wr_en = 1'b1; addr = a; wdata = d; flip = f;
        tick();
        wr_en = 1'b0; flip = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d,
                           output logic pe, output logic ok);
        ok = 1'b0; d = '0; pe = 1'b0;
        rd_en = 1'b1; addr = a;
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (valid_rd === 1'b1) begin
                ok = 1'b1; d = rdata; pe = par_err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({rdata, valid_rd, valid_wr, busy, err_conf, par_err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {rdata, valid_rd, valid_wr, busy, err_conf, par_err});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; addr = 8'h03; wdata = 8'h5A;
        tick();
        wr_en = 1'b0;
        checks++;
        if (valid_wr !== 1'b1) begin
            errors++; $display("FAIL wr_ack got=%b want=1", valid_wr);
        end
        tick();
        checks++;
        if (valid_wr !== 1'b0) begin
            errors++; $display("FAIL wr_ack_pulse got=%b want=0", valid_wr);
        end
        rd_en = 1'b1; addr = 8'h03;
        tick();
        rd_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || valid_rd !== 1'b0) begin
            errors++;
            $display("FAIL rd_edge0 busy=%b vrd=%b want busy=1 vrd=0", busy, valid_rd);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || valid_rd !== 1'b0) begin
            errors++;
            $display("FAIL rd_edge1 busy=%b vrd=%b want busy=1 vrd=0", busy, valid_rd);
        end
        tick();
        checks++;
        if (valid_rd !== 1'b1 || rdata !== 8'h5A || busy !== 1'b0 || par_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_edge2 vrd=%b data=%h busy=%b pe=%b want 1 5a 0 0",
                     valid_rd, rdata, busy, par_err);
        end
        tick();
        checks++;
        if (valid_rd !== 1'b0 || rdata !== 8'h5A) begin
            errors++;
            $display("FAIL rd_hold vrd=%b data=%h want 0 5a", valid_rd, rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_write(8'h01, 8'hC3, 1'b0);
        do_write(8'h04, 8'h77, 1'b0);
        do_write(8'h05, 8'hEE, 1'b0);
        vr_cnt = 0;
        rd_en = 1'b1; addr = 8'h01;
        tick();
        addr = 8'h05;
        tick();
        rd_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || valid_rd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop busy=%b vrd=%b want 1 0", busy, valid_rd);
        end
        tick();
        checks++;
        if (valid_rd !== 1'b1 || rdata !== 8'hC3) begin
            errors++;
            $display("FAIL b2b_first vrd=%b data=%h want 1 c3", valid_rd, rdata);
        end
        rd_en = 1'b1; addr = 8'h04;
        tick();
        rd_en = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept busy=%b want 1", busy);
        end
        tick();
        tick();
        checks++;
        if (valid_rd !== 1'b1 || rdata !== 8'h77) begin
            errors++;
            $display("FAIL b2b_third vrd=%b data=%h want 1 77", valid_rd, rdata);
        end
        tick();
        tick();
        tick();
        checks++;
        if (vr_cnt != 2) begin
            errors++; $display("FAIL b2b_pulses got=%0d want=2", vr_cnt);
        end
    endtask

    task automatic test_write_during_read();
        do_write(8'h07, 8'h22, 1'b0);
        rd_en = 1'b1; addr = 8'h07;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b1; addr = 8'h07; wdata = 8'h11;
        tick();
        wr_en = 1'b0;
        checks++;
        if (valid_wr !== 1'b1) begin
            errors++; $display("FAIL wdr_ack got=%b want=1", valid_wr);
        end
        tick();
        checks++;
        if (valid_rd !== 1'b1 || rdata !== 8'h11) begin
            errors++;
            $display("FAIL wdr_data vrd=%b data=%h want 1 11", valid_rd, rdata);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic [7:0] d;
        logic pe, ok;
        do_write(8'h02, 8'h33, 1'b0);
        rd_en = 1'b1; wr_en = 1'b1; addr = 8'h02; wdata = 8'h99;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        checks++;
        if (err_conf !== 1'b1 || valid_wr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL conf_pulse err=%b ack=%b busy=%b want 1 0 0",
                     err_conf, valid_wr, busy);
        end
        tick();
        checks++;
        if (err_conf !== 1'b0 || valid_rd !== 1'b0) begin
            errors++;
            $display("FAIL conf_after err=%b vrd=%b want 0 0", err_conf, valid_rd);
        end
        do_read(8'h02, d, pe, ok);
        checks++;
        if (!ok || d !== 8'h33) begin
            errors++; $display("FAIL conf_mem ok=%b data=%h want 1 33", ok, d);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        logic pe, ok;
        do_write(8'h09, 8'h6E, 1'b0);
        rd_en = 1'b1; addr = 8'h09;
        tick();
        rd_en = 1'b0;
        vr_cnt = 0;
        rst = 1'b1;
        #1;
        checks++;
        if ({rdata, valid_rd, valid_wr, busy, err_conf, par_err} !== 13'd0) begin
            errors++;
            $display("FAIL rst_mid got=%h want=0",
                     {rdata, valid_rd, valid_wr, busy, err_conf, par_err});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (vr_cnt != 0) begin
            errors++; $display("FAIL rst_abort pulses=%0d want=0", vr_cnt);
        end
        do_read(8'h09, d, pe, ok);
        checks++;
        if (!ok || d !== 8'h6E) begin
            errors++; $display("FAIL rst_mem ok=%b data=%h want 1 6e", ok, d);
        end
    endtask

    task automatic test_addr_bounds();
        logic [7:0] d;
        logic pe, ok;
        do_write(8'h00, 8'h01, 1'b0);
        do_write(8'hFF, 8'hFE, 1'b0);
        do_read(8'h00, d, pe, ok);
        checks++;
        if (!ok || d !== 8'h01) begin
            errors++; $display("FAIL addr_lo ok=%b data=%h want 1 01", ok, d);
        end
        do_read(8'hFF, d, pe, ok);
        checks++;
        if (!ok || d !== 8'hFE) begin
            errors++; $display("FAIL addr_hi ok=%b data=%h want 1 fe", ok, d);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic pe, ok;
        logic exp_pe;
`ifdef SORT_RAM_PARITY_EN
        exp_pe = 1'b1;
`else
        exp_pe = 1'b0;
`endif
        do_write(8'h0A, 8'hA5, 1'b1);
        do_read(8'h0A, d, pe, ok);
        checks++;
        if (!ok || d !== 8'hA5 || pe !== exp_pe) begin
            errors++;
            $display("FAIL parity_flip ok=%b data=%h pe=%b want 1 a5 %b",
                     ok, d, pe, exp_pe);
        end
        tick();
        checks++;
        if (par_err !== 1'b0) begin
            errors++; $display("FAIL parity_idle pe=%b want 0", par_err);
        end
        do_write(8'h0B, 8'hA5, 1'b0);
        do_read(8'h0B, d, pe, ok);
        checks++;
        if (!ok || d !== 8'hA5 || pe !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean ok=%b data=%h pe=%b want 1 a5 0", ok, d, pe);
        end
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        addr = '0; wdata = '0; flip = 1'b0;
        #2;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_write_during_read();
        test_conflict();
        test_reset_mid_read();
        test_addr_bounds();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
